alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the alu.
- Registers decoded operands and control, translates the 2-bit main ALU op plus funct into the 4-bit ALUOp, and forwards EX/MEM and MEM/WB results onto A/B.
- Detects load-use hazards and stalls decode.
- Downstream: alu (A, B, ALUOp) and EX/MEM register (ex_* fields).

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode presents instruction
- id_ready  out  1  stage accepts instruction this cycle
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_rs, id_rt, id_rd  in  REG_AW  source/destination indices
- id_imm  in  16  immediate
- id_alusrc  in  1  1 = B takes sign-extended imm
- id_aluop  in  2  00 add, 01 sub, 10 R-type (funct), 11 reserved
- id_funct  in  6  R-type funct
- id_memread, id_memwrite, id_regwrite  in  1  control
- ex_stall  in  1  downstream hold
- flush  in  1  kill stage contents
- exm_regwrite  in  1; exm_rd  in  REG_AW; exm_result  in  DATA_W  EX/MEM producer
- wb_regwrite  in  1; wb_rd  in  REG_AW; wb_result  in  DATA_W  MEM/WB producer
- A, B  out  DATA_W  alu operands
- ALUOp  out  4  alu operation
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_illegal  out  1
- ex_rd  out  REG_AW
- ex_store_data  out  DATA_W  forwarded rt value

Behaviour:
- Reset, synchronous, active-high: all regs 0, so ex_valid=0, ALUOp=0000, ex_rd=0, control flags 0; A=B=0 unless forwarding matches (rd=0 never matches).
- Register update priority, per edge:
  - rst.
  - flush: ex_valid/regwrite/memread/memwrite <= 0.
  - ex_stall: hold all.
  - id_valid && id_ready: capture.
  - else: bubble (valid/control flags 0).
- Latency: 1 cycle from accept to ex_valid.
- Load-use: load_use = ex_valid && ex_memread && ex_rd!=0 && id_valid && (id_rs==ex_rd || id_rt==ex_rd).
- id_ready = !ex_stall && !load_use; independent of flush.
- Instruction not accepted (id_ready low): decode must hold it.
- ALUOp decode, registered at capture:
  - aluop 00 -> 0010; aluop 01 -> 0110.
  - aluop 10: funct 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 100111 -> 1100, 101010 -> 0111.
  - Other funct or aluop 11: ALUOp=0000, ex_illegal=1, ex_regwrite/memwrite forced 0.
- Operands:
  - imm sign-extended to DATA_W at capture.
  - A = fwd(rs).
  - B = alusrc_q ? imm_q : fwd(rt).
  - ex_store_data = fwd(rt).
- fwd(x), combinational from registered fields:
  - EX/MEM match (regwrite && rd==x && rd!=0) first.
  - Else WB match.
  - Else registered data.
- Simultaneous flush+stall: flush wins.
- Stall with forwarding: A/B track live forward inputs while held.

Optional Feature:
- Macro ALU_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - A/B/ex_store_data come from registered data only; exm_*/wb_* unused except exm_regwrite/exm_rd.
  - id_ready also deasserts when id_rs/id_rt (nonzero) matches ex_rd with ex_valid&&ex_regwrite, or exm_rd with exm_regwrite.
  - WB hazards are covered by register-file write-before-read.

Decomposition:
- Package alu_pkg:
  - ALUOp codes AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
  - Main aluop encodings.
  - Funct constants.
- Sub-module alu_ctrl: combinational aluop/funct -> ALUOp + illegal.

Test Plan:
- rst=1 two cycles -> ex_valid=0, ALUOp=0000, A=B=0, id_ready=1.
- aluop=10 funct=100000 rs_data=5 rt_data=7 rd=2 -> next cycle ALUOp=0010 A=5 B=7 ex_rd=2 ex_valid=1.
- Forwarding (ALU_FWD_EN):
  - EX rs=3; exm rd=3 result 0x1234 and wb rd=3 result 0x9999 -> A=0x00001234.
  - exm_rd=0 -> A=registered data.
- alusrc=1 imm=0xFFFE aluop=01 -> B=0xFFFFFFFE, ALUOp=0110.
- Load-use: EX holds load rd=4, decode rs=4 -> id_ready=0, next cycle ex_valid=0, following cycle instruction captured.
- Flush+stall together -> ex_valid=0.
- Stall alone -> all outputs held.
- funct=000000 aluop=10 -> ex_illegal=1, ex_regwrite=0, ALUOp=0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand stage: ALUOp codes, main aluop
// encodings and R-type funct values.
package alu_pkg;

  // ALUOp codes seen by the alu.
  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_SLT = 4'b0111;
  localparam logic [3:0] ALUOP_NOR = 4'b1100;

  // Two-bit main aluop produced by decode.
  typedef enum logic [1:0] {
    MAIN_ADD   = 2'b00,
    MAIN_SUB   = 2'b01,
    MAIN_RTYPE = 2'b10,
    MAIN_RSVD  = 2'b11
  } main_op_e;

  // R-type funct values.
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl.sv
// Combinational ALU control: maps main aluop + funct onto the 4-bit ALUOp.
// Unknown funct codes and the reserved main op flag the instruction illegal
// and fall back to ALUOP_AND.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic [1:0] main_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  // Decode table; defaults first so nothing latches.
  always_comb begin
    alu_op_o  = ALUOP_AND;
    illegal_o = 1'b0;
    case (main_op_e'(main_op_i))
      MAIN_ADD: alu_op_o = ALUOP_ADD;
      MAIN_SUB: alu_op_o = ALUOP_SUB;
      MAIN_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: alu_op_o = ALUOP_ADD;
          FUNCT_SUB: alu_op_o = ALUOP_SUB;
          FUNCT_AND: alu_op_o = ALUOP_AND;
          FUNCT_OR:  alu_op_o = ALUOP_OR;
          FUNCT_NOR: alu_op_o = ALUOP_NOR;
          FUNCT_SLT: alu_op_o = ALUOP_SLT;
          default:   illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register stage feeding the alu. Captures decoded operands and
// control, decodes ALUOp, detects load-use hazards and supplies A/B.
// Build option ALU_FWD_EN: when defined, EX/MEM and MEM/WB results are
// forwarded onto A/B/ex_store_data; when undefined, operands come from the
// registered data only and decode is stalled on any in-flight RAW producer
// (ID/EX or EX/MEM), relying on register-file write-before-read for WB.
//
// Handshake: decode offers an instruction with id_valid; it is taken on a
// rising edge where id_valid && id_ready. id_ready depends only on ex_stall,
// hazards and current stage contents (never on flush). While id_ready is
// low decode must keep the same instruction on its outputs.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [15:0]       id_imm,
  input  logic              id_alusrc,
  input  logic [1:0]        id_aluop,
  input  logic [5:0]        id_funct,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_regwrite,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              exm_regwrite,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [3:0]        ALUOp,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_illegal,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_store_data
);

  logic [3:0] ctrl_op;
  logic       ctrl_illegal;

  alu_ctrl u_alu_ctrl (
    .main_op_i (id_aluop),
    .funct_i   (id_funct),
    .alu_op_o  (ctrl_op),
    .illegal_o (ctrl_illegal)
  );

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q,  memread_d;
  logic              memwrite_q, memwrite_d;
  logic              illegal_q,  illegal_d;
  logic              alusrc_q,   alusrc_d;
  logic [3:0]        aluop_q,    aluop_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [REG_AW-1:0] rs_q,       rs_d;
  logic [REG_AW-1:0] rt_q,       rt_d;
  logic [DATA_W-1:0] rs_data_q,  rs_data_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;

  logic [DATA_W-1:0] imm_ext;
  logic              load_use;
  logic              raw_hazard;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  assign imm_ext = {{(DATA_W-16){id_imm[15]}}, id_imm};

  // A load in EX cannot be forwarded in time to a dependent instruction.
  assign load_use = valid_q && memread_q && (rd_q != '0) && id_valid &&
                    ((id_rs == rd_q) || (id_rt == rd_q));

`ifdef ALU_FWD_EN
  assign raw_hazard = 1'b0;

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  assign rs_val = (exm_regwrite && (exm_rd != '0) && (exm_rd == rs_q)) ? exm_result :
                  (wb_regwrite  && (wb_rd  != '0) && (wb_rd  == rs_q)) ? wb_result  :
                  rs_data_q;
  assign rt_val = (exm_regwrite && (exm_rd != '0) && (exm_rd == rt_q)) ? exm_result :
                  (wb_regwrite  && (wb_rd  != '0) && (wb_rd  == rt_q)) ? wb_result  :
                  rt_data_q;
`else
  logic rs_busy;
  logic rt_busy;
  logic unused_fwd;

  // Without forwarding, any producer still in ID/EX or EX/MEM blocks decode.
  assign rs_busy = (id_rs != '0) &&
                   ((valid_q && regwrite_q && (id_rs == rd_q)) ||
                    (exm_regwrite && (id_rs == exm_rd)));
  assign rt_busy = (id_rt != '0) &&
                   ((valid_q && regwrite_q && (id_rt == rd_q)) ||
                    (exm_regwrite && (id_rt == exm_rd)));
  assign raw_hazard = rs_busy || rt_busy;

  assign rs_val     = rs_data_q;
  assign rt_val     = rt_data_q;
  assign unused_fwd = ^{exm_result, wb_regwrite, wb_rd, wb_result, rs_q, rt_q};
`endif

  assign id_ready = !ex_stall && !load_use && !raw_hazard;

  // Next-state selection: flush, then stall hold, then capture, else bubble.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    illegal_d  = illegal_q;
    alusrc_d   = alusrc_q;
    aluop_d    = aluop_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      illegal_d  = 1'b0;
    end else if (ex_stall) begin
      valid_d = valid_q;
    end else if (id_valid && id_ready) begin
      valid_d    = 1'b1;
      regwrite_d = id_regwrite && !ctrl_illegal;
      memread_d  = id_memread;
      memwrite_d = id_memwrite && !ctrl_illegal;
      illegal_d  = ctrl_illegal;
      alusrc_d   = id_alusrc;
      aluop_d    = ctrl_op;
      rd_d       = id_rd;
      rs_d       = id_rs;
      rt_d       = id_rt;
      rs_data_d  = id_rs_data;
      rt_data_d  = id_rt_data;
      imm_d      = imm_ext;
    end else begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      illegal_d  = 1'b0;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      illegal_q  <= illegal_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
    end
  end

  assign A             = rs_val;
  assign B             = alusrc_q ? imm_q : rt_val;
  assign ex_store_data = rt_val;
  assign ALUOp         = aluop_q;
  assign ex_valid      = valid_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_illegal    = illegal_q;
  assign ex_rd         = rd_q;

endmodule
